// File: rtl/if_prefetch_buffer_pkg.sv
// riscv_defines: shared word width, FIFO entry layout and prefetch FSM states
package riscv_defines;
   localparam int WORD_WIDTH = 32;
   typedef struct packed {
      logic [WORD_WIDTH-1:0] addr;
      logic [WORD_WIDTH-1:0] instr;
   } fetch_entry_t;
   typedef enum logic {PF_IDLE, PF_RUN} pf_state_e;
endpackage

// File: rtl/if_prefetch_buffer_fifo.sv
// sync_fifo: register-based FIFO with flush, occupancy count and no read bypass
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   // pointers and occupancy; flush discards everything, including a same-cycle push
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   // storage array, contents only meaningful while counted
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end
   assign valid = count != '0;
   assign rdata = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: pipelined req/gnt/rvalid instruction fetch with branch flush
module if_prefetch_buffer #(
   parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
   parameter int DEPTH      = 4,
   parameter int MAX_OUTST  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_en_i,
   input  logic [WORD_WIDTH-1:0] pc_start_addr_i,
   input  logic                  branch_i,
   input  logic [WORD_WIDTH-1:0] branch_addr_i,
   output logic                  instr_req_o,
   output logic [WORD_WIDTH-1:0] instr_addr_o,
   input  logic                  instr_gnt_i,
   input  logic                  instr_rvalid_i,
   input  logic [WORD_WIDTH-1:0] instr_rdata_i,
   output logic                  fetch_valid_o,
   input  logic                  fetch_ready_i,
   output logic [WORD_WIDTH-1:0] fetch_instr_o,
   output logic [WORD_WIDTH-1:0] fetch_addr_o,
   output logic                  busy_o
);
   import riscv_defines::*;
   localparam int OW = $clog2(MAX_OUTST+1);
   localparam int CW = $clog2(DEPTH+1);
   pf_state_e             state;
   pf_state_e             state_next;
   logic [WORD_WIDTH-1:0] issue_pc;
   logic [WORD_WIDTH-1:0] resp_pc;
   logic [WORD_WIDTH-1:0] stale_addr;
   logic [OW-1:0]         outstanding;
   logic [OW-1:0]         outstanding_next;
   logic [OW-1:0]         discard;
   logic [CW-1:0]         fifo_count;
   logic                  hold;
   logic                  stale;
   logic                  run;
   logic                  br;
   logic                  gnt;
   logic                  rv;
   logic                  drop;
   logic                  push;
   logic                  pop;
   assign run = state == PF_RUN;
   assign br  = run & branch_i;
   // a raised request stays up until granted; otherwise issue only with reserved FIFO space
   assign instr_req_o = run & (hold | (fetch_en_i & (int'(outstanding) < MAX_OUTST)
                                       & (int'(fifo_count) + int'(outstanding) < DEPTH)));
   assign instr_addr_o     = stale ? stale_addr : issue_pc;
   assign gnt              = instr_req_o & instr_gnt_i;
   assign rv               = instr_rvalid_i & (outstanding != '0);
   assign drop             = rv & (discard != '0);
   assign push             = rv & ~drop & ~br;
   assign pop              = fetch_valid_o & fetch_ready_i & ~br;
   assign outstanding_next = outstanding + OW'(gnt) - OW'(rv);
   assign busy_o           = (outstanding != '0) | (discard != '0);
   // state register
   always_ff @(posedge clk) begin
      state <= rst ? PF_IDLE : state_next;
   end
   // IDLE leaves on fetch enable; RUN is only left through reset
   always_comb begin
      state_next = (state == PF_IDLE && fetch_en_i) ? PF_RUN : state;
   end
   // PCs, in-flight bookkeeping and the stale (pre-branch) request tracker
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_pc    <= '0;
         resp_pc     <= '0;
         stale_addr  <= '0;
         outstanding <= '0;
         discard     <= '0;
         hold        <= 1'b0;
         stale       <= 1'b0;
      end else begin
         outstanding <= outstanding_next;
         hold        <= instr_req_o & ~instr_gnt_i;
         if (state == PF_IDLE && fetch_en_i) begin
            issue_pc <= pc_start_addr_i;
            resp_pc  <= pc_start_addr_i;
         end else if (br) begin
            issue_pc   <= branch_addr_i;
            resp_pc    <= branch_addr_i;
            discard    <= outstanding_next;
            stale      <= instr_req_o & ~instr_gnt_i;
            stale_addr <= instr_addr_o;
         end else begin
            if (gnt) stale <= 1'b0;
            if (gnt && !stale) issue_pc <= issue_pc + WORD_WIDTH'(4);
            if (push) resp_pc <= resp_pc + WORD_WIDTH'(4);
            discard <= discard + OW'(gnt & stale) - OW'(drop);
         end
      end
   end
   sync_fifo #(
      .WIDTH(2*WORD_WIDTH),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (br),
      .push  (push),
      .pop   (pop),
      .wdata ({resp_pc, instr_rdata_i}),
      .rdata ({fetch_addr_o, fetch_instr_o}),
      .valid (fetch_valid_o),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb_if_prefetch_buffer: table-driven corner cases plus randomized stream vs an address-sequence model
module tb_if_prefetch_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b0;
   logic [31:0] pc_start = '0;
   logic        branch = 1'b0;
   logic [31:0] baddr = '0;
   logic        ready = 1'b0;
   logic        t_gnt = 1'b0;
   logic        t_rv = 1'b0;
   logic [31:0] t_rdata = '0;
   logic        auto_m = 1'b0;
   logic        m_roll = 1'b0;
   logic        m_rv = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        req;
   logic [31:0] addr;
   logic        fvalid;
   logic [31:0] finstr;
   logic [31:0] faddr;
   logic        busy;
   logic        gnt_in;
   logic        rv_in;
   logic [31:0] rdata_in;
   int          checks = 0;
   int          failures = 0;
   int          gnt_pct = 100;
   int          rv_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   int          cyc = 0;
   logic [31:0] exp_pc = '0;
   logic [31:0] pend_addr = '0;
   logic        pend = 1'b0;
   logic        model_on = 1'b0;
   int          n_gnt = 0;
   int          n_pop = 0;
   typedef struct {logic [31:0] a; int t;} mreq_t;
   mreq_t q[$];
   typedef struct {
      logic en, gnt, rv; logic [31:0] ra; logic rdy, br; logic [31:0] ba;
      logic req; logic [31:0] addr; logic val; logic [31:0] fa; logic busy;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   assign gnt_in   = auto_m ? (req & m_roll) : t_gnt;
   assign rv_in    = auto_m ? m_rv : t_rv;
   assign rdata_in = auto_m ? m_rdata : t_rdata;

   if_prefetch_buffer dut (
      .clk(clk), .rst(rst), .fetch_en_i(fetch_en), .pc_start_addr_i(pc_start),
      .branch_i(branch), .branch_addr_i(baddr), .instr_req_o(req), .instr_addr_o(addr),
      .instr_gnt_i(gnt_in), .instr_rvalid_i(rv_in), .instr_rdata_i(rdata_in),
      .fetch_valid_o(fvalid), .fetch_ready_i(ready), .fetch_instr_o(finstr),
      .fetch_addr_o(faddr), .busy_o(busy));

   function automatic logic [31:0] d(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic vec_t v(input int en, gn, rvv, ra, rdy, br, ba, rq, ad, val, fa, bs);
      vec_t r;
      r.en = en[0]; r.gnt = gn[0]; r.rv = rvv[0]; r.ra = 32'(ra); r.rdy = rdy[0];
      r.br = br[0]; r.ba = 32'(ba); r.req = rq[0]; r.addr = 32'(ad); r.val = val[0];
      r.fa = 32'(fa); r.busy = bs[0];
      return r;
   endfunction

   // in-order memory model: grants at random, answers after a random latency
   always @(posedge clk) begin
      if (rst) q.delete();
      else if (auto_m) begin
         if (rv_in) void'(q.pop_front());
         if (req && gnt_in) q.push_back('{addr, cyc + int'($urandom_range(lat_max, lat_min))});
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      m_roll  <= int'($urandom_range(99, 0)) < gnt_pct;
      m_rv    <= !rst && auto_m && q.size() != 0 && q[0].t <= cyc && int'($urandom_range(99, 0)) < rv_pct;
      m_rdata <= q.size() != 0 ? d(q[0].a) : 32'h0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, {31'd0, req}, 0);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_valid"}, {31'd0, fvalid}, 0);
      chk({tag, "_faddr"}, faddr, 0);
      chk({tag, "_finstr"}, finstr, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
   endtask

   // per-cycle check in auto mode: request stability and the fetched address stream
   task automatic tick();
      #1;
      if (pend) begin
         chk("hold_req", {31'd0, req}, 1);
         chk("hold_addr", addr, pend_addr);
      end
      pend = req & ~gnt_in;
      pend_addr = addr;
      if (req && gnt_in) n_gnt++;
      if (model_on) begin
         chk("outst_le_max", {31'd0, q.size() <= 2}, 1);
         if (branch) exp_pc = baddr;
         else if (fvalid && ready) begin
            chk("stream_addr", faddr, exp_pc);
            chk("stream_instr", finstr, d(exp_pc));
            exp_pc += 4;
            n_pop++;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bit got;
      tbl.push_back(v(1,0,0,'h000,1,0,'h000, 0,'h000,0,'h000,0));
      tbl.push_back(v(1,1,0,'h000,1,0,'h000, 1,'h100,0,'h000,0));
      tbl.push_back(v(1,1,1,'h100,1,0,'h000, 1,'h104,0,'h000,1));
      tbl.push_back(v(1,1,1,'h104,1,0,'h000, 1,'h108,1,'h100,1));
      tbl.push_back(v(1,1,1,'h108,1,0,'h000, 1,'h10C,1,'h104,1));
      tbl.push_back(v(1,1,1,'h10C,1,1,'h200, 1,'h110,1,'h108,1));
      tbl.push_back(v(1,1,1,'h110,1,0,'h000, 1,'h200,0,'h000,1));
      tbl.push_back(v(1,0,1,'h200,1,0,'h000, 1,'h204,0,'h000,1));
      tbl.push_back(v(1,0,0,'h000,0,0,'h000, 1,'h204,1,'h200,0));
      tbl.push_back(v(0,0,0,'h000,0,1,'h300, 1,'h204,1,'h200,0));
      tbl.push_back(v(1,0,0,'h000,1,0,'h000, 1,'h204,0,'h000,0));
      tbl.push_back(v(1,0,0,'h000,1,0,'h000, 1,'h204,0,'h000,0));
      tbl.push_back(v(1,1,0,'h000,1,0,'h000, 1,'h204,0,'h000,0));
      tbl.push_back(v(1,1,1,'h204,1,0,'h000, 1,'h300,0,'h000,1));
      tbl.push_back(v(1,0,1,'h300,1,0,'h000, 1,'h304,0,'h000,1));
      tbl.push_back(v(0,0,0,'h000,1,0,'h000, 1,'h304,1,'h300,0));
      tbl.push_back(v(0,1,0,'h000,1,0,'h000, 1,'h304,0,'h000,0));
      tbl.push_back(v(0,0,1,'h304,1,0,'h000, 0,'h308,0,'h000,1));
      tbl.push_back(v(0,0,0,'h000,1,0,'h000, 0,'h308,1,'h304,0));
      pc_start = 32'h100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk_all_zero("reset");
      // directed: streaming, branch with same-cycle gnt+rvalid, slow grant across a branch
      foreach (tbl[i]) begin
         @(negedge clk);
         rst = 1'b0;
         fetch_en = tbl[i].en; t_gnt = tbl[i].gnt; t_rv = tbl[i].rv;
         t_rdata = tbl[i].rv ? d(tbl[i].ra) : 32'h0; ready = tbl[i].rdy;
         branch = tbl[i].br; baddr = tbl[i].ba;
         #1;
         chk($sformatf("t%0d_req", i), {31'd0, req}, {31'd0, tbl[i].req});
         chk($sformatf("t%0d_addr", i), addr, tbl[i].addr);
         chk($sformatf("t%0d_valid", i), {31'd0, fvalid}, {31'd0, tbl[i].val});
         chk($sformatf("t%0d_faddr", i), faddr, tbl[i].fa);
         chk($sformatf("t%0d_finstr", i), finstr, tbl[i].val ? d(tbl[i].fa) : 32'h0);
         chk($sformatf("t%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      end
      // backpressure: ready low, requests stop once FIFO plus in-flight reach DEPTH
      @(negedge clk);
      rst = 1'b1; fetch_en = 1'b0; branch = 1'b0; t_gnt = 1'b0; t_rv = 1'b0; ready = 1'b0;
      auto_m = 1'b1; pc_start = 32'h400;
      repeat (2) @(negedge clk);
      rst = 1'b0; fetch_en = 1'b1; pend = 1'b0; model_on = 1'b1; exp_pc = 32'h400; n_gnt = 0;
      tick();
      repeat (14) begin @(negedge clk); tick(); end
      chk("bp_grants", 32'(n_gnt), 4);
      chk("bp_full_valid", {31'd0, fvalid}, 1);
      chk("bp_req_low", {31'd0, req}, 0);
      n_pop = 0;
      repeat (12) begin @(negedge clk); ready = 1'b1; tick(); end
      chk("bp_drain", {31'd0, n_pop >= 4}, 1);
      // reset with two requests in flight, then a clean restart
      lat_min = 2; lat_max = 2; got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk); tick();
         got = q.size() == 2;
      end
      chk("reach_two_outst", {31'd0, got}, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk_all_zero("midrst");
      pc_start = 32'h800; rst = 1'b0; pend = 1'b0; exp_pc = 32'h800; n_pop = 0;
      lat_min = 1;
      repeat (40) begin @(negedge clk); tick(); end
      chk("restart_pops", {31'd0, n_pop >= 5}, 1);
      // randomized: grants, latency, stalls, fetch enable and branches (including PC wrap)
      gnt_pct = 70; rv_pct = 75; lat_max = 3; n_pop = 0;
      repeat (3000) begin
         @(negedge clk);
         fetch_en = ($urandom % 8) != 0;
         ready = ($urandom % 4) != 0;
         branch = ($urandom % 24) == 0;
         baddr = ($urandom % 5) == 0 ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         tick();
      end
      chk("random_progress", {31'd0, n_pop > 300}, 1);
      repeat (25) begin
         @(negedge clk);
         fetch_en = 1'b0; branch = 1'b0; ready = 1'b1;
         tick();
      end
      chk("drain_busy", {31'd0, busy}, 0);
      chk("drain_valid", {31'd0, fvalid}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
